// File: rtl/emul_bus_pkg.sv
// Shared types for the Emulator parallel-bus receiver: strobe indices and FIFO entry.
package emul_bus_pkg;

  localparam int DATA_W   = 8;
  localparam int NUM_STB  = 8;
  localparam int NUM_EDGE = 7;

  // Bit positions of each strobe in the synchroniser vector
  typedef enum logic [2:0] {
    ST_MS_ADDR  = 3'd0,
    ST_MS_DATA  = 3'd1,
    ST_IN12_AN  = 3'd2,
    ST_IN12_CA  = 3'd3,
    ST_IN12_CLR = 3'd4,
    ST_KB_WR    = 3'd5,
    ST_KB_CLR   = 3'd6,
    ST_KB_RD    = 3'd7
  } strobe_e;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ms_pair_t;

endpackage

// File: rtl/emul_bus_fifo.sv
// Show-ahead FIFO of MS6205 address/data pairs; a pop frees a slot for a same-cycle push.
module emul_bus_fifo
  import emul_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  ms_pair_t               wdata,
  input  logic                   pop,
  output ms_pair_t               rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  ms_pair_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/emul_bus_receiver.sv
// Peripheral end of the Emulator strobed bus: MS6205 pair FIFO, IN-12 latches, keyboard matrix.
// Optional KBD_DEBOUNCE_EN adds per-row debounce counters on the keyboard read path.
module emul_bus_receiver
  import emul_bus_pkg::*;
#(
  parameter int FIFO_DEPTH      = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [DATA_W-1:0] emulData_in,
  output logic [DATA_W-1:0] emulData_out,
  output logic              emulData_oe,
  input  logic              ms6205_write_addr,
  input  logic              ms6205_write_data,
  input  logic              in12_write_anode,
  input  logic              in12_write_cathode,
  input  logic              in12_clear,
  input  logic              keyboard_write,
  input  logic              keyboard_read,
  input  logic              keyboard_clear,
  output logic [DATA_W-1:0] ms_addr,
  output logic [DATA_W-1:0] ms_data,
  output logic              ms_valid,
  input  logic              ms_ready,
  output logic              ms_overflow,
  output logic [DATA_W-1:0] in12_anode,
  output logic [DATA_W-1:0] in12_cathode,
  output logic [DATA_W-1:0] kbd_col,
  input  logic [DATA_W-1:0] kbd_rows
);

  logic [NUM_STB-1:0]  stb_raw, s1, s2;
  logic [NUM_EDGE-1:0] s3, edge_det;
  logic [DATA_W-1:0]   addr_hold, rows_m, rows_s, rows_eff, live_out, hold_out;
  ms_pair_t            push_pair, head;
  logic                push, pop, full, empty, rd_s;
  logic [$clog2(FIFO_DEPTH):0] count;

  assign stb_raw = {keyboard_read, keyboard_clear, keyboard_write, in12_clear,
                    in12_write_cathode, in12_write_anode, ms6205_write_data, ms6205_write_addr};

  // Third stage only for the edge-triggered strobes; keyboard_read is a level
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1     <= '0;
      s2     <= '0;
      s3     <= '0;
      rows_m <= '0;
      rows_s <= '0;
    end else begin
      s1     <= stb_raw;
      s2     <= s1;
      s3     <= s2[NUM_EDGE-1:0];
      rows_m <= kbd_rows;
      rows_s <= rows_m;
    end
  end

  assign edge_det = s2[NUM_EDGE-1:0] & ~s3;
  assign rd_s     = s2[ST_KB_RD];

  // A same-cycle address strobe feeds the pushed pair directly
  assign push_pair.addr = edge_det[ST_MS_ADDR] ? emulData_in : addr_hold;
  assign push_pair.data = emulData_in;
  assign push           = edge_det[ST_MS_DATA];
  assign pop            = ms_ready & ~empty;

  emul_bus_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (Clk),
    .rst_n (Rst_n),
    .push  (push),
    .wdata (push_pair),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign ms_valid = (count != '0);
  assign ms_addr  = head.addr;
  assign ms_data  = head.data;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      addr_hold    <= '0;
      in12_anode   <= '0;
      in12_cathode <= '0;
      kbd_col      <= '0;
      ms_overflow  <= 1'b0;
      hold_out     <= '0;
    end else begin
      if (edge_det[ST_MS_ADDR]) addr_hold <= emulData_in;
      if (push && full && !pop) ms_overflow <= 1'b1;
      if (edge_det[ST_IN12_CLR]) begin
        in12_anode   <= '0;
        in12_cathode <= '0;
      end else begin
        if (edge_det[ST_IN12_AN]) in12_anode   <= emulData_in;
        if (edge_det[ST_IN12_CA]) in12_cathode <= emulData_in;
      end
      if (edge_det[ST_KB_CLR])     kbd_col <= '0;
      else if (edge_det[ST_KB_WR]) kbd_col <= emulData_in;
      if (rd_s) hold_out <= live_out;
    end
  end

`ifdef KBD_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [DATA_W-1:0] rows_q, col_q, rows_deb;
  logic              col_chg;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rows_q <= '0;
      col_q  <= '0;
    end else begin
      rows_q <= rows_s;
      col_q  <= kbd_col;
    end
  end

  assign col_chg = (kbd_col != col_q);

  for (genvar i = 0; i < DATA_W; i++) begin : g_deb
    logic [CW-1:0] cnt;
    logic          deb;
    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        cnt <= '0;
        deb <= 1'b0;
      end else if ((rows_s[i] != rows_q[i]) || col_chg) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb <= rows_q[i];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
    assign rows_deb[i] = deb;
  end

  assign rows_eff = rows_deb;
`else
  assign rows_eff = rows_s;
`endif

  assign live_out     = rows_eff & {DATA_W{|kbd_col}};
  assign emulData_oe  = rd_s;
  assign emulData_out = rd_s ? live_out : hold_out;

endmodule

// File: tb/tb_emul_bus_receiver.sv
// Self-checking bench for emul_bus_receiver: directed scenarios plus randomized strobe traffic vs a queue model.
module tb_emul_bus_receiver;
  import emul_bus_pkg::*;

  logic              Clk = 1'b0;
  logic              Rst_n = 1'b0;
  logic [DATA_W-1:0] emulData_in = '0;
  logic [DATA_W-1:0] emulData_out;
  logic              emulData_oe;
  logic [6:0]        stb = '0;
  logic              keyboard_read = 1'b0;
  logic [DATA_W-1:0] ms_addr, ms_data, in12_anode, in12_cathode, kbd_col;
  logic              ms_valid, ms_overflow;
  logic              ms_ready = 1'b0;
  logic [DATA_W-1:0] kbd_rows = '0;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state
  logic [15:0]      q_model[$];
  logic [7:0]       m_hold, m_an, m_ca, m_col;
  logic             m_ovf;

  always #5 Clk = ~Clk;

  emul_bus_receiver dut (
    .Clk               (Clk),
    .Rst_n             (Rst_n),
    .emulData_in       (emulData_in),
    .emulData_out      (emulData_out),
    .emulData_oe       (emulData_oe),
    .ms6205_write_addr (stb[0]),
    .ms6205_write_data (stb[1]),
    .in12_write_anode  (stb[2]),
    .in12_write_cathode(stb[3]),
    .in12_clear        (stb[4]),
    .keyboard_write    (stb[5]),
    .keyboard_read     (keyboard_read),
    .keyboard_clear    (stb[6]),
    .ms_addr           (ms_addr),
    .ms_data           (ms_data),
    .ms_valid          (ms_valid),
    .ms_ready          (ms_ready),
    .ms_overflow       (ms_overflow),
    .in12_anode        (in12_anode),
    .in12_cathode      (in12_cathode),
    .kbd_col           (kbd_col),
    .kbd_rows          (kbd_rows)
  );

  task automatic model_reset();
    q_model.delete();
    m_hold = '0; m_an = '0; m_ca = '0; m_col = '0; m_ovf = 1'b0;
  endtask

  // Apply one set of simultaneous strobes to the model
  task automatic model_apply(input logic [6:0] m, input logic [7:0] d);
    if (m[0]) m_hold = d;
    if (m[1]) begin
      if (q_model.size() >= 4) m_ovf = 1'b1;
      else q_model.push_back({m_hold, d});
    end
    if (m[4]) begin m_an = '0; m_ca = '0; end
    else begin
      if (m[2]) m_an = d;
      if (m[3]) m_ca = d;
    end
    if (m[6]) m_col = '0;
    else if (m[5]) m_col = d;
  endtask

  task automatic pulse(input logic [6:0] m, input logic [7:0] d);
    @(negedge Clk);
    emulData_in = d;
    stb = m;
    repeat (5) @(negedge Clk);
    stb = '0;
    repeat (3) @(negedge Clk);
    model_apply(m, d);
  endtask

  task automatic check_latches(input string tag);
    total_cnt++;
    if ({in12_anode, in12_cathode, kbd_col, ms_overflow} !== {m_an, m_ca, m_col, m_ovf})
      $display("FAIL %s latches: got an=%h ca=%h col=%h ovf=%b, want an=%h ca=%h col=%h ovf=%b",
               tag, in12_anode, in12_cathode, kbd_col, ms_overflow, m_an, m_ca, m_col, m_ovf);
    else pass_cnt++;
  endtask

  // Pop every modelled entry and compare head, then confirm empty
  task automatic drain(input string tag);
    logic [15:0] exp;
    while (q_model.size() > 0) begin
      exp = q_model.pop_front();
      @(negedge Clk);
      total_cnt++;
      if (ms_valid !== 1'b1 || {ms_addr, ms_data} !== exp)
        $display("FAIL %s pop: got v=%b %h/%h, want v=1 %h/%h", tag, ms_valid, ms_addr, ms_data,
                 exp[15:8], exp[7:0]);
      else pass_cnt++;
      ms_ready = 1'b1;
      @(negedge Clk);
      ms_ready = 1'b0;
    end
    total_cnt++;
    if (ms_valid !== 1'b0) $display("FAIL %s empty: got ms_valid=%b, want 0", tag, ms_valid);
    else pass_cnt++;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    model_reset();
    @(negedge Clk);
  endtask

  task automatic test_reset();
    do_reset();
    check_latches("reset");
    total_cnt++;
    if ({ms_valid, emulData_oe, emulData_out} !== 10'b0)
      $display("FAIL reset outs: got v=%b oe=%b out=%h, want 0", ms_valid, emulData_oe, emulData_out);
    else pass_cnt++;
  endtask

  task automatic test_addr_reuse();
    pulse(7'h01, 8'h12);
    pulse(7'h02, 8'hA5);
    pulse(7'h02, 8'h5A);
    drain("addr_reuse");
    // Address and data strobes together: push uses the new address
    pulse(7'h03, 8'h3C);
    drain("addr_data_same");
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      pulse(7'h02, d);
    end
    check_latches("overflow");
    drain("overflow");
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 3; i++) pulse(7'h07, 8'($urandom));
    pulse(7'h20, 8'h40);
    @(negedge Clk);
    emulData_in = 8'h77;
    stb = 7'h02;
    @(negedge Clk);
    Rst_n = 1'b0;
    stb = '0;
    #1;
    total_cnt++;
    if ({ms_valid, ms_overflow, in12_anode, in12_cathode, kbd_col} !== 26'b0)
      $display("FAIL reset_async: got v=%b ovf=%b an=%h ca=%h col=%h, want 0",
               ms_valid, ms_overflow, in12_anode, in12_cathode, kbd_col);
    else pass_cnt++;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    model_reset();
    repeat (4) @(negedge Clk);
    check_latches("reset_mid_burst");
    total_cnt++;
    if (ms_valid !== 1'b0) $display("FAIL reset_mid_burst valid: got %b, want 0", ms_valid);
    else pass_cnt++;
  endtask

  task automatic test_in12_priority();
    pulse(7'h04, 8'h04);
    pulse(7'h08, 8'h09);
    check_latches("in12_set");
    pulse(7'h14, 8'($urandom));
    check_latches("in12_clr_prio");
    pulse(7'h68, 8'h55);
    check_latches("kb_clr_prio");
  endtask

  task automatic test_random();
    logic [6:0] m;
    for (int i = 0; i < 40; i++) begin
      m = 7'($urandom);
      pulse(m, 8'($urandom));
      check_latches("random");
      if (q_model.size() >= 4 || $urandom_range(0, 3) == 0) drain("random");
    end
    drain("random_end");
  endtask

  task automatic kbd_case(input logic [7:0] col, input logic [7:0] rows, input string tag);
    logic [7:0] exp;
    kbd_rows = rows;
    if (col == 0) pulse(7'h40, 8'h00);
    else pulse(7'h20, col);
    exp = rows & {8{|col}};
    repeat (25) @(negedge Clk);
    keyboard_read = 1'b1;
    repeat (3) @(negedge Clk);
    total_cnt++;
    if (emulData_oe !== 1'b1 || emulData_out !== exp)
      $display("FAIL %s read: got oe=%b out=%h, want oe=1 out=%h", tag, emulData_oe, emulData_out, exp);
    else pass_cnt++;
    keyboard_read = 1'b0;
    repeat (3) @(negedge Clk);
    kbd_rows = 8'($urandom);
    repeat (3) @(negedge Clk);
    total_cnt++;
    if (emulData_oe !== 1'b0 || emulData_out !== exp)
      $display("FAIL %s hold: got oe=%b out=%h, want oe=0 out=%h", tag, emulData_oe, emulData_out, exp);
    else pass_cnt++;
  endtask

  task automatic test_keyboard();
    logic [7:0] exp;
    kbd_case(8'h02, 8'h81, "kbd_basic");
    kbd_case(8'h00, 8'hFF, "kbd_nocol");
    for (int i = 0; i < 4; i++) kbd_case(8'($urandom_range(1, 255)), 8'($urandom), "kbd_rand");
    // keyboard_clear during an active read drops the output to zero
    kbd_rows = 8'h81;
    pulse(7'h20, 8'h02);
    repeat (25) @(negedge Clk);
    keyboard_read = 1'b1;
    repeat (3) @(negedge Clk);
    pulse(7'h40, 8'h00);
    exp = 8'h00;
    total_cnt++;
    if (emulData_oe !== 1'b1 || emulData_out !== exp)
      $display("FAIL kbd_clear: got oe=%b out=%h, want oe=1 out=%h", emulData_oe, emulData_out, exp);
    else pass_cnt++;
    keyboard_read = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

`ifdef KBD_DEBOUNCE_EN
  task automatic test_debounce();
    bit seen;
    int n;
    kbd_rows = 8'h00;
    pulse(7'h20, 8'h01);
    repeat (25) @(negedge Clk);
    keyboard_read = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      kbd_rows = (i % 2 == 0) ? 8'h01 : 8'h00;
      repeat (5) @(negedge Clk);
      if (emulData_out !== 8'h00) seen = 1'b1;
    end
    kbd_rows = 8'h01;
    repeat (12) @(negedge Clk);
    if (emulData_out !== 8'h00) seen = 1'b1;
    total_cnt++;
    if (seen) $display("FAIL debounce_bounce: got nonzero output during bounce, want 00");
    else pass_cnt++;
    n = 0;
    while (emulData_out !== 8'h01 && n < 30) begin
      @(negedge Clk);
      n++;
    end
    total_cnt++;
    if (emulData_out !== 8'h01) $display("FAIL debounce_settle: got %h, want 01", emulData_out);
    else pass_cnt++;
    keyboard_read = 1'b0;
    repeat (3) @(negedge Clk);
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_addr_reuse();
    test_overflow();
    test_reset_mid_burst();
    test_in12_priority();
    test_random();
    test_keyboard();
`ifdef KBD_DEBOUNCE_EN
    test_debounce();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
